// File: rtl/spi_pkg.sv
// Shared types for the multi-mode SPI master: FSM states, latched mode bits
// and the smallest half-period that still samples miso reliably.
package spi_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } mode_t;

  // miso crosses a 2-flop synchronizer, so a half-period shorter than this
  // samples stale data.
  localparam int MIN_DIV = 3;

endpackage

// File: rtl/spi_halfper_timer.sv
// Half-period timer: counts clk cycles and pulses tick on the d-th cycle,
// then restarts. Held at zero while clear is high.
module spi_halfper_timer #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [DIV_W-1:0] d,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = !clear && (cnt == d - DIV_W'(1));

  always_ff @(posedge clk) begin
    if (rst || clear || tick) cnt <= '0;
    else                      cnt <= cnt + DIV_W'(1);
  end

endmodule

// File: rtl/spi_master_mc.sv
// Parametrised SPI master: all four CPOL/CPHA modes, runtime divider,
// variable length, MSB/LSB-first and one-hot chip selects.
import spi_pkg::*;

module spi_master_mc #(
  parameter int DATA_W = 32,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 16,
  parameter int LEN_W  = $clog2(DATA_W) + 1,
  parameter int SEL_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [SEL_W-1:0]  cs_sel,
  input  logic [LEN_W-1:0]  len,
  input  logic [DIV_W-1:0]  div,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              miso,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              sck,
  output logic              mosi,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int IDX_W = $clog2(DATA_W);

  state_t            state_q, state_d;
  mode_t             mode_q;
  logic [LEN_W-1:0]  l_q, bit_cnt, l_in;
  logic [LEN_W:0]    edge_cnt;
  logic [DIV_W-1:0]  d_q, d_in;
  logic [DATA_W-1:0] tx_q, rx_shift;
  logic [NUM_CS-1:0] cs_init;
  logic [IDX_W-1:0]  first_pos;
  logic              miso_s1, miso_s2;
  logic              tick, accept, edge_now, hold_done, sample_now;

  spi_halfper_timer #(.DIV_W(DIV_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (state_q == IDLE),
    .d     (d_q),
    .tick  (tick)
  );

  // Clamped transfer parameters and chip-select pattern, taken from the inputs at accept.
  always_comb begin
    l_in      = ((len == '0) || (len > LEN_W'(DATA_W))) ? LEN_W'(DATA_W) : len;
    d_in      = (div == '0) ? DIV_W'(1) : div;
    first_pos = lsb_first ? '0 : IDX_W'(l_in - LEN_W'(1));
    cs_init   = '1;
    for (int i = 0; i < NUM_CS; i++) cs_init[i] = (SEL_W'(i) != cs_sel);
  end

  // Bit k of the transfer maps to this word position in both tx and rx.
  function automatic logic [IDX_W-1:0] bit_pos(input logic [LEN_W-1:0] k);
    return mode_q.lsb_first ? IDX_W'(k) : IDX_W'(l_q - k - LEN_W'(1));
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // The first SCK edge leaves SETUP; SHIFT then spends one more half-period after the last edge.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    edge_now  = 1'b0;
    hold_done = 1'b0;
    unique case (state_q)
      IDLE:  if (start) begin accept = 1'b1; state_d = SETUP; end
      SETUP: if (tick) begin edge_now = 1'b1; state_d = SHIFT; end
      SHIFT: if (tick) begin
               if (edge_cnt == {l_q, 1'b0}) state_d = HOLD;
               else                         edge_now = 1'b1;
             end
      HOLD:  if (tick) begin hold_done = 1'b1; state_d = GAP; end
      GAP:   if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign sample_now = edge_now && (~edge_cnt[0] ^ mode_q.cpha);

  always_ff @(posedge clk) begin
    if (rst) begin
      sck      <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= '1;
      done     <= 1'b0;
      rx_data  <= '0;
      rx_shift <= '0;
      tx_q     <= '0;
      mode_q   <= '0;
      l_q      <= '0;
      d_q      <= DIV_W'(1);
      bit_cnt  <= '0;
      edge_cnt <= '0;
      miso_s1  <= 1'b0;
      miso_s2  <= 1'b0;
    end else begin
      miso_s1 <= miso;
      miso_s2 <= miso_s1;
      done    <= hold_done;
      if (state_q == IDLE) sck <= cpol;
      if (state_q == HOLD) sck <= mode_q.cpol;
      if (accept) begin
        mode_q   <= '{cpol: cpol, cpha: cpha, lsb_first: lsb_first};
        l_q      <= l_in;
        d_q      <= d_in;
        tx_q     <= tx_data;
        cs_n     <= cs_init;
        bit_cnt  <= '0;
        edge_cnt <= '0;
        rx_shift <= '0;
        if (!cpha) mosi <= tx_data[first_pos];
      end
      if (edge_now) begin
        sck      <= ~sck;
        edge_cnt <= edge_cnt + (LEN_W+1)'(1);
        if (sample_now) begin
          rx_shift[bit_pos(bit_cnt)] <= miso_s2;
          if (mode_q.cpha) bit_cnt <= bit_cnt + LEN_W'(1);
        end else if (mode_q.cpha) begin
          mosi <= tx_q[bit_pos(bit_cnt)];
        end else if (bit_cnt != l_q - LEN_W'(1)) begin
          bit_cnt <= bit_cnt + LEN_W'(1);
          mosi    <= tx_q[bit_pos(bit_cnt + LEN_W'(1))];
        end
      end
      if (hold_done) begin
        cs_n    <= '1;
        rx_data <= rx_shift;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_mc.sv
// Directed bench for spi_master_mc: table of transfers with hand-computed
// timing/data, plus start-held and mid-transfer reset sequences.
module tb_spi_master_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, cpol, cpha, lsb_first;
  logic [2:0]  cs_sel;
  logic [5:0]  len;
  logic [15:0] div;
  logic [31:0] tx_data, rx_data;
  logic        miso, busy, done, sck, mosi;
  logic [3:0]  cs_n;

  logic        slave_en = 1'b0;
  logic [31:0] slave_word = '0;
  logic        slave_bit = 1'b0;
  logic [4:0]  slave_k = '0;

  int          cyc = 0, edge_total = 0, rise_total = 0, done_total = 0;
  int          cs_low_total = 0, bad_mosi = 0;
  logic [31:0] cap_seq = '0;
  logic        prev_sck = 1'b0, prev_mosi = 1'b0, prev_busy = 1'b0;

  int          errors = 0, checks = 0;

  typedef struct {
    logic        cpol, cpha, lsb;
    logic [2:0]  sel;
    logic [5:0]  len;
    logic [15:0] div;
    logic [31:0] tx;
    logic        slave_en;
    logic [31:0] slave_word;
    int          n_bits;
    logic [3:0]  exp_cs;
    int          exp_edges, exp_rises, exp_cs_low, exp_done, exp_busy;
    logic [31:0] exp_rx, exp_seq;
  } vec_t;

  vec_t vecs[6];

  assign miso = slave_en ? slave_bit : mosi;

  always #5 clk = ~clk;

  spi_master_mc #(.DATA_W(32), .NUM_CS(4), .DIV_W(16), .LEN_W(6), .SEL_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .cpol(cpol), .cpha(cpha),
    .lsb_first(lsb_first), .cs_sel(cs_sel), .len(len), .div(div),
    .tx_data(tx_data), .miso(miso), .rx_data(rx_data), .busy(busy),
    .done(done), .sck(sck), .mosi(mosi), .cs_n(cs_n)
  );

  // Line monitor and slave model, evaluated 1 ns after each active edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (busy && sck != prev_sck) begin
      edge_total++;
      if (sck) rise_total++;
      if (cpha ? (sck == cpol) : (sck != cpol)) cap_seq = {cap_seq[30:0], mosi};
      if (sck != cpol && slave_en) begin
        slave_bit = slave_word[slave_k];
        slave_k   = slave_k + 5'd1;
      end
    end
    if (busy && prev_busy && mosi != prev_mosi &&
        !(sck != prev_sck && (cpha ? (sck != cpol) : (sck == cpol)))) bad_mosi++;
    if (!busy) slave_k = '0;
    if (done) done_total++;
    if (cs_n != 4'hF) cs_low_total++;
    prev_sck  = sck;
    prev_mosi = mosi;
    prev_busy = busy;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_for_done(input int budget, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
  endtask

  task automatic wait_busy_low(input int budget, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (!busy) seen = 1'b1;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    cpol = v.cpol; cpha = v.cpha; lsb_first = v.lsb;
    cs_sel = v.sel; len = v.len; div = v.div; tx_data = v.tx;
    slave_en = v.slave_en; slave_word = v.slave_word;
    @(negedge clk);
  endtask

  task automatic run_vector(input vec_t v, input int idx);
    int          t0, e0, r0, d0, c0, b0;
    logic        seen;
    logic [31:0] mask;
    applyStimulus(v);
    checkOutput($sformatf("v%0d idle_sck", idx), 32'(sck), 32'(v.cpol));
    e0 = edge_total; r0 = rise_total; d0 = done_total; c0 = cs_low_total; b0 = bad_mosi;
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    checkOutput($sformatf("v%0d cs_fall", idx), 32'(cs_n), 32'(v.exp_cs));
    checkOutput($sformatf("v%0d busy_rise", idx), 32'(busy), 32'd1);
    wait_for_done(1000, seen);
    checkOutput($sformatf("v%0d done_seen", idx), 32'(seen), 32'd1);
    checkOutput($sformatf("v%0d done_cycle", idx), 32'(cyc - t0), 32'(v.exp_done));
    checkOutput($sformatf("v%0d rx_data", idx), rx_data, v.exp_rx);
    checkOutput($sformatf("v%0d cs_rise", idx), 32'(cs_n), 32'hF);
    wait_busy_low(100, seen);
    checkOutput($sformatf("v%0d busy_fall", idx), 32'(cyc - t0), 32'(v.exp_busy));
    checkOutput($sformatf("v%0d rx_hold", idx), rx_data, v.exp_rx);
    checkOutput($sformatf("v%0d sck_edges", idx), 32'(edge_total - e0), 32'(v.exp_edges));
    checkOutput($sformatf("v%0d sck_rises", idx), 32'(rise_total - r0), 32'(v.exp_rises));
    checkOutput($sformatf("v%0d done_pulses", idx), 32'(done_total - d0), 32'd1);
    checkOutput($sformatf("v%0d cs_low_cycles", idx), 32'(cs_low_total - c0), 32'(v.exp_cs_low));
    checkOutput($sformatf("v%0d mosi_edge", idx), 32'(bad_mosi - b0), 32'd0);
    mask = (v.n_bits == 32) ? 32'hFFFF_FFFF : ((32'h1 << v.n_bits) - 32'h1);
    checkOutput($sformatf("v%0d mosi_order", idx), cap_seq & mask, v.exp_seq);
  endtask

  initial begin
    int          t0, d0, r0;
    logic        seen;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 3'd1, 6'd8,  16'd4, 32'h0000_00A5, 1'b0, 32'h0,
                8,  4'b1101, 16, 8,  72,  73,  77,  32'h0000_00A5, 32'h0000_00A5};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 3'd0, 6'd16, 16'd3, 32'h0000_1234, 1'b1, 32'h0000_BEEF,
                16, 4'b1110, 32, 16, 102, 103, 106, 32'h0000_BEEF, 32'h0000_2C48};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 3'd2, 6'd0,  16'd3, 32'hDEAD_BEEF, 1'b0, 32'h0,
                32, 4'b1011, 64, 32, 198, 199, 202, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 3'd3, 6'd40, 16'd4, 32'hDEAD_BEEF, 1'b0, 32'h0,
                32, 4'b0111, 64, 32, 264, 265, 269, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 3'd5, 6'd4,  16'd3, 32'h0000_0009, 1'b0, 32'h0,
                4,  4'b1111, 8,  4,  0,   31,  34,  32'h0000_0009, 32'h0000_0009};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 3'd0, 6'd5,  16'd3, 32'hFFFF_FF13, 1'b0, 32'h0,
                5,  4'b1110, 10, 5,  36,  37,  40,  32'h0000_0013, 32'h0000_0013};

    rst = 1'b1; start = 1'b0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    cs_sel = '0; len = 6'd8; div = 16'd3; tx_data = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset cs_n", 32'(cs_n), 32'hF);
    checkOutput("reset sck", 32'(sck), 32'd0);
    checkOutput("reset mosi", 32'(mosi), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset rx_data", rx_data, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vector(vecs[i], i);

    // start held high with tx_data changed mid-transfer
    @(negedge clk);
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; cs_sel = 3'd0;
    len = 6'd8; div = 16'd3; tx_data = 32'h3C; slave_en = 1'b0;
    @(negedge clk);
    d0 = done_total;
    start = 1'b1;
    t0 = cyc;
    repeat (6) @(negedge clk);
    tx_data = 32'hFF;
    wait_for_done(1000, seen);
    checkOutput("held done_seen", 32'(seen), 32'd1);
    checkOutput("held done_cycle", 32'(cyc - t0), 32'd55);
    checkOutput("held rx_first", rx_data, 32'h3C);
    wait_busy_low(100, seen);
    checkOutput("held busy_fall", 32'(cyc - t0), 32'd58);
    checkOutput("held one_done", 32'(done_total - d0), 32'd1);
    @(negedge clk);
    start = 1'b0;
    checkOutput("held restart_busy", 32'(busy), 32'd1);
    checkOutput("held restart_cs", 32'(cs_n), 32'hE);
    wait_for_done(1000, seen);
    checkOutput("held rx_second", rx_data, 32'hFF);
    wait_busy_low(100, seen);
    checkOutput("held two_done", 32'(done_total - d0), 32'd2);

    // reset during SHIFT after the third rising SCK edge
    applyStimulus(vecs[0]);
    r0 = rise_total;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && (rise_total - r0) < 3; i++) @(negedge clk);
    checkOutput("abort reached_bit3", 32'(rise_total - r0), 32'd3);
    d0 = done_total;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort cs_n", 32'(cs_n), 32'hF);
    checkOutput("abort sck", 32'(sck), 32'd0);
    checkOutput("abort mosi", 32'(mosi), 32'd0);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort rx_data", rx_data, 32'h0);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    checkOutput("abort no_done", 32'(done_total - d0), 32'd0);
    run_vector(vecs[0], 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
